// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU for the MIPS datapath.
//
// Single-cycle operations (AND/OR/ADD/SUB/XOR/NOR/SLTU/SLT) complete at the
// accepting edge. MULT/MULTU/DIV/DIVU run an iterative shift-add or restoring
// shift-subtract engine for WIDTH cycles, then one fix-up cycle that applies
// the sign correction and writes the HI/LO pair. A valid/ready handshake lets
// the control unit stall while a multiply or divide is in flight.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   an operation is presented
//   in_ready   the block can accept an operation (low while busy or in reset)
//   alucont    4-bit operation code
//   src1/src2  operands (src1 = dividend / minuend)
//   out_valid  one-cycle pulse: result, hi and flags were updated
//   result     ALU result; LO for multiply, quotient for divide
//   hi         upper product or remainder (written only by mul/div)
//   zero       result == 0
//   ovf        signed overflow on ADD/SUB
//   dz         divide by zero
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucont,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dz
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Iteration datapath (scratch state, meaningful only while busy)
    logic [2*WIDTH-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   mag_b;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   dividend;   // src1 as captured, returned as hi on divide by zero
    logic [CNTW-1:0]    count;
    logic               op_div;
    logic               neg_q;      // product / quotient must be negated
    logic               neg_r;      // remainder must be negated (dividend was negative)
    logic               div_zero;

    // -------------------------------------------------------------------------
    // Handshake and opcode decode
    // -------------------------------------------------------------------------
    logic accept, is_muldiv, signed_mode, last_step;

    assign in_ready    = (state_q == IDLE) && !reset;
    assign accept      = in_valid && in_ready;
    assign is_muldiv   = (alucont[3:2] == 2'b10);
    assign signed_mode = ~alucont[0];     // MULT/DIV are even codes, MULTU/DIVU odd
    assign last_step   = (count == CNTW'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // Single-cycle ALU
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, alu_legal;

    assign sum  = src1 + src2;
    assign diff = src1 - src2;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_legal = 1'b1;
        unique case (alucont)
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_XOR:  alu_res = src1 ^ src2;
            OP_NOR:  alu_res = ~(src1 | src2);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            default: alu_legal = 1'b0;   // mul/div codes never complete here; others are illegal
        endcase
    end

    // -------------------------------------------------------------------------
    // One multiply or divide step
    // -------------------------------------------------------------------------
    logic [WIDTH:0]     mul_add;
    logic [WIDTH:0]     rem_sh, trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole pair right by one.
        mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        mul_next = {mul_add, acc[WIDTH-1:1]};

        // Restoring divide: bring the next dividend bit into the remainder and
        // keep the subtraction only if it did not go negative.
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial  = rem_sh - {1'b0, mag_b};
        if (!trial[WIDTH])
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // -------------------------------------------------------------------------
    // Fix-up: sign correction and divide-by-zero substitution
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_res, fix_hi;

    always_comb begin
        prod = neg_q ? -acc : acc;
        if (!op_div) begin
            fix_res = prod[WIDTH-1:0];
            fix_hi  = prod[2*WIDTH-1:WIDTH];
        end else if (div_zero) begin
            fix_res = '1;
            fix_hi  = dividend;
        end else begin
            fix_res = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_hi  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && is_muldiv) state_d = ITER;
            ITER:    if (last_step) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the iteration registers are deliberately left without reset; they
    // are always loaded at accept before being read, and keeping them out of
    // the reset branch avoids gating their enables with reset.
    always_ff @(posedge clk) begin
        if (accept && is_muldiv) begin
            logic s1n, s2n;
            logic [WIDTH-1:0] mag1, mag2;
            s1n  = signed_mode && src1[WIDTH-1];
            s2n  = signed_mode && src2[WIDTH-1];
            mag1 = s1n ? -src1 : src1;
            mag2 = s2n ? -src2 : src2;
            op_div   <= alucont[1];
            neg_q    <= s1n ^ s2n;
            neg_r    <= s1n;
            div_zero <= alucont[1] && (src2 == '0);
            dividend <= src1;
            count    <= '0;
            if (alucont[1]) begin
                mag_b <= mag2;
                acc   <= {{WIDTH{1'b0}}, mag1};
            end else begin
                mag_b <= mag1;
                acc   <= {{WIDTH{1'b0}}, mag2};
            end
        end else if (state_q == ITER) begin
            acc   <= op_div ? div_next : mul_next;
            count <= count + CNTW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            hi        <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_muldiv) begin
                result    <= alu_res;
                // Illegal opcodes clear every flag, including zero.
                zero      <= alu_legal && (alu_res == '0);
                ovf       <= alu_ovf;
                dz        <= 1'b0;
                out_valid <= 1'b1;
            end else if (state_q == FIX) begin
                result    <= fix_res;
                hi        <= fix_hi;
                zero      <= (fix_res == '0);
                ovf       <= 1'b0;
                dz        <= op_div && div_zero;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
